// File: rtl/covox_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : covox_feeder_pkg
//  Description : Shared definitions for the covox sample feeder: control-byte
//                bit positions, status-word layout and reset defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package covox_feeder_pkg;

    // Bit positions inside the byte written with ctrl_wr
    localparam int unsigned c_CTRL_EN    = 7;  // playback enable (level)
    localparam int unsigned c_CTRL_FLUSH = 6;  // one-shot FIFO flush
    localparam int unsigned c_CTRL_CLR   = 5;  // one-shot sticky-flag clear

    // Bit positions inside the 4-bit status word
    localparam int unsigned c_STAT_FULL  = 3;
    localparam int unsigned c_STAT_EMPTY = 2;
    localparam int unsigned c_STAT_OVF   = 1;
    localparam int unsigned c_STAT_UDR   = 0;

    // DAC mid-scale: silence for an unsigned 8-bit covox
    localparam logic [7:0] c_RESET_LEVEL = 8'h80;

    // Status word, MSB first; field order matches the c_STAT_* positions
    typedef struct packed {
        logic full;
        logic empty;
        logic overflow;
        logic underrun;
    } status_t;

endpackage : covox_feeder_pkg
`default_nettype wire

// File: rtl/covox_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : covox_fifo_ram
//  Description : Sample storage for the covox feeder, 2^DEPTH_LOG2 x 8 bits.
//                Synchronous write port, asynchronous (combinational) read
//                port. Contents are deliberately not reset.
//  Ports       : clk       - system clock
//                i_wr_en   - write strobe
//                i_wr_addr - write address
//                i_wr_data - write data
//                i_rd_addr - read address
//                o_rd_data - read data (combinational from i_rd_addr)
//  Revision    : 1.0 - initial release
// ============================================================================
module covox_fifo_ram #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [7:0]            i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [7:0]            o_rd_data
);

    localparam int unsigned c_DEPTH = 1 << DEPTH_LOG2;

    logic [7:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : covox_fifo_ram
`default_nettype wire

// File: rtl/covox_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : covox_feeder
//  Description : Rate-timed sample FIFO feeding an 8-bit covox DAC. The CPU
//                pushes samples; a programmable down-counter pops one sample
//                every div+1 cycles onto dout, qualified by a covox_wr pulse.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                din       - CPU data bus
//                sample_wr - push din into the FIFO
//                ctrl_wr   - write {enable, flush, clear-flags} from din[7:5]
//                div_wr    - write din into the rate divider
//                dout      - sample delivered to the covox stage
//                covox_wr  - one-cycle strobe qualifying dout
//                level     - FIFO occupancy
//                status    - {full, empty, overflow, underrun}
//                half_irq  - enabled and FIFO at most half full
//  Revision    : 1.0 - initial release
// ============================================================================
module covox_feeder
    import covox_feeder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter logic [7:0]  RESET_LEVEL = c_RESET_LEVEL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          din,
    input  logic                sample_wr,
    input  logic                ctrl_wr,
    input  logic                div_wr,
    output logic [7:0]          dout,
    output logic                covox_wr,
    output logic [DEPTH_LOG2:0] level,
    output logic [3:0]          status,
    output logic                half_irq
);

    localparam int unsigned             c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]     c_LVL_MAX = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]     c_LVL_HALF = (DEPTH_LOG2+1)'(c_DEPTH / 2);
    localparam logic [DEPTH_LOG2:0]     c_LVL_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0]   c_PTR_ONE = DEPTH_LOG2'(1);

    // Registered state
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_enable;
    logic [7:0]            r_div;
    logic [7:0]            r_count;
    logic                  r_overflow;
    logic                  r_underrun;
    logic [7:0]            r_dout;
    logic                  r_covox_wr;

    // Combinational qualifiers for the current cycle
    logic                  w_tick;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_flush;
    logic                  w_clear;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf_set;
    logic                  w_udr_set;
    logic [7:0]            w_rd_data;
    status_t               w_status;

    assign w_full  = (r_level == c_LVL_MAX);
    assign w_empty = (r_level == '0);
    assign w_tick  = r_enable && (r_count == 8'd0);
    assign w_flush = ctrl_wr && din[c_CTRL_FLUSH];
    assign w_clear = ctrl_wr && din[c_CTRL_CLR];

    // Flush swallows any push or pop issued alongside it. A push into a full
    // FIFO is still accepted when the same cycle frees a slot by popping.
    assign w_pop     = w_tick && !w_empty && !w_flush;
    assign w_push    = sample_wr && !w_flush && (!w_full || w_pop);
    assign w_ovf_set = sample_wr && !w_flush && w_full && !w_pop;
    // Underrun reflects a tick that found nothing to play, flush or not.
    assign w_udr_set = w_tick && w_empty;

    covox_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (din),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Control register and rate timer. While disabled the counter tracks
    // div, so enabling yields the first tick div+1 cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_div    <= 8'd0;
            r_count  <= 8'd0;
        end else begin
            if (ctrl_wr) begin
                r_enable <= din[c_CTRL_EN];
            end
            if (div_wr) begin
                r_div   <= din;
                r_count <= din;
            end else if (!r_enable || w_tick) begin
                r_count <= r_div;
            end else begin
                r_count <= r_count - 8'd1;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overflow <= w_ovf_set || (r_overflow && !w_clear);
            r_underrun <= w_udr_set || (r_underrun && !w_clear);
        end
    end

    // Output stage: the popped head is registered, covox_wr follows by one
    // cycle. Reset drops any pop in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= RESET_LEVEL;
            r_covox_wr <= 1'b0;
        end else begin
            r_covox_wr <= w_pop;
            if (w_pop) begin
                r_dout <= w_rd_data;
            end
        end
    end

    assign w_status.full     = w_full;
    assign w_status.empty    = w_empty;
    assign w_status.overflow = r_overflow;
    assign w_status.underrun = r_underrun;

    assign dout     = r_dout;
    assign covox_wr = r_covox_wr;
    assign level    = r_level;
    assign status   = w_status;
    assign half_irq = r_enable && (r_level <= c_LVL_HALF);

endmodule : covox_feeder
`default_nettype wire
